// File: rtl/info_frame_pkg.sv
// info_frame_pkg -- shared types and helpers for the runtime-loadable InfoFrame source.
//   - InfoFrame type codes (AVI / SPD / AUDIO)
//   - subpacket_t : four 56-bit subpackets; byte j of the flat vector is PB j
//   - ld_state_t  : shadow loader states
//   - build_header / checksum helpers
package info_frame_pkg;

    localparam logic [6:0] TYPE_AVI   = 7'h02;
    localparam logic [6:0] TYPE_SPD   = 7'h03;
    localparam logic [6:0] TYPE_AUDIO = 7'h04;

    // PB0..PB27 packed LSB-first: sub[i] byte k is PB(7i+k)
    typedef logic [3:0][55:0] subpacket_t;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_PENDING
    } ld_state_t;

    function automatic logic [23:0] build_header(input logic [6:0] t,
                                                 input logic [7:0] ver,
                                                 input logic [7:0] len);
        return {len, ver, 1'b1, t};
    endfunction

    // PB0 makes the byte sum of header + payload wrap to zero
    function automatic logic [7:0] checksum(input logic [6:0] t,
                                            input logic [7:0] ver,
                                            input logic [7:0] len,
                                            input logic [7:0] sum);
        logic [7:0] s;
        s = {1'b1, t} + ver + len + sum;
        return 8'h00 - s;
    endfunction

endpackage

// File: rtl/dynamic_info_frame_if.sv
// dynamic_info_frame_if -- byte write port, packet offer port and status flags.
//   master : the side that loads bytes, pulses frame_start and accepts packets
//   slave  : the InfoFrame source (dynamic_info_frame)
interface dynamic_info_frame_if;
    import info_frame_pkg::*;

    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic        wr_last;
    logic        frame_start;
    logic        tx_valid;
    logic        tx_ready;
    logic [23:0] header;
    subpacket_t  sub;
    logic        overflow;
    logic        missed;

    modport master (
        output wr_valid, wr_data, wr_last, frame_start, tx_ready,
        input  wr_ready, tx_valid, header, sub, overflow, missed
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, frame_start, tx_ready,
        output wr_ready, tx_valid, header, sub, overflow, missed
    );

endinterface

// File: rtl/info_frame_shadow_loader.sv
// info_frame_shadow_loader -- collects PB1..PBn into a shadow buffer.
//   clk_pixel, reset_n : clock, synchronous active-low reset
//   wr_valid/wr_ready/wr_data/wr_last : byte stream, wr_last commits the load
//   swap       : active buffer is taking the shadow this cycle (releases PENDING)
//   pending    : a committed load waits for the swap
//   length     : byte count of the committed load
//   shadow_sub : shadow bytes with the registered checksum in PB0
//   overflow   : sticky, some load ran past MAX_LENGTH
module info_frame_shadow_loader
    import info_frame_pkg::*;
#(
    parameter logic [6:0] TYPE       = TYPE_AVI,
    parameter logic [7:0] VERSION    = 8'h02,
    parameter int         MAX_LENGTH = 27
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    input  logic       wr_last,
    output logic       wr_ready,
    input  logic       swap,
    output logic       pending,
    output logic [7:0] length,
    output subpacket_t shadow_sub,
    output logic       overflow
);

    ld_state_t         state, state_nxt;
    logic [27:1][7:0]  shadow;
    logic [7:0]        count, sum, csum;
    logic              load_ovf;
    logic              accept, fresh, fits, commit;
    logic [7:0]        count_nxt, sum_nxt;

    assign accept    = wr_valid && wr_ready;
    // A byte accepted in IDLE opens a new load, so it sees an empty count/sum.
    assign fresh     = (state == LD_IDLE);
    assign fits      = fresh || (count < 8'(MAX_LENGTH));
    assign count_nxt = fresh ? 8'd1    : count + 8'd1;
    assign sum_nxt   = fresh ? wr_data : sum + wr_data;
    assign commit    = accept && wr_last && fits && (fresh || !load_ovf);

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) state <= LD_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LD_IDLE, LD_LOAD: begin
                if (accept) begin
                    if (!wr_last)    state_nxt = LD_LOAD;
                    else if (commit) state_nxt = LD_PENDING;
                    else             state_nxt = LD_IDLE;   // overflowed load dropped
                end
            end
            LD_PENDING: if (swap) state_nxt = LD_IDLE;
            default:    state_nxt = LD_IDLE;
        endcase
    end

    always_comb begin
        wr_ready = 1'b1;
        pending  = 1'b0;
        if (state == LD_PENDING) begin
            wr_ready = 1'b0;
            pending  = 1'b1;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            shadow   <= '0;
            count    <= '0;
            sum      <= '0;
            csum     <= '0;
            load_ovf <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            if (fresh) begin
                shadow   <= '0;     // the byte write below overrides its own slot
                load_ovf <= 1'b0;
            end
            if (fits) begin
                for (int j = 1; j <= 27; j++)
                    if (count_nxt == 8'(j)) shadow[j] <= wr_data;
                count <= count_nxt;
                sum   <= sum_nxt;
            end else begin
                load_ovf <= 1'b1;
                overflow <= 1'b1;
            end
            if (commit) csum <= checksum(TYPE, VERSION, count_nxt, sum_nxt);
        end
    end

    assign length     = count;
    assign shadow_sub = subpacket_t'({shadow, csum});

endmodule

// File: rtl/dynamic_info_frame.sv
// dynamic_info_frame -- double-buffered, runtime-loadable HDMI InfoFrame source.
//   clk_pixel : pixel clock
//   reset_n   : synchronous active-low reset
//   bus       : dynamic_info_frame_if.slave
//               wr_* byte load port, frame_start pulse, tx_valid/tx_ready offer
//               of header + sub, sticky overflow / missed flags
// Optional feature macro: INFO_FRAME_REPEAT_EN -- re-offer the active packet
// every REPEAT_INTERVAL frames; without it a packet is offered once per swap.
module dynamic_info_frame
    import info_frame_pkg::*;
#(
    parameter logic [6:0] TYPE            = TYPE_AVI,
    parameter logic [7:0] VERSION         = 8'h02,
    parameter int         MAX_LENGTH      = 27,
    parameter int         REPEAT_INTERVAL = 1
) (
    input  logic                 clk_pixel,
    input  logic                 reset_n,
    dynamic_info_frame_if.slave  bus
);

    logic       pending, swap, handshake, active_valid, rep_fire;
    logic [7:0] length;
    subpacket_t shadow_sub;

    assign swap      = bus.frame_start && pending;
    assign handshake = bus.tx_valid && bus.tx_ready;

    info_frame_shadow_loader #(
        .TYPE       (TYPE),
        .VERSION    (VERSION),
        .MAX_LENGTH (MAX_LENGTH)
    ) u_loader (
        .clk_pixel  (clk_pixel),
        .reset_n    (reset_n),
        .wr_valid   (bus.wr_valid),
        .wr_data    (bus.wr_data),
        .wr_last    (bus.wr_last),
        .wr_ready   (bus.wr_ready),
        .swap       (swap),
        .pending    (pending),
        .length     (length),
        .shadow_sub (shadow_sub),
        .overflow   (bus.overflow)
    );

`ifdef INFO_FRAME_REPEAT_EN
    logic [7:0] rep_cnt;
    logic       rep_wrap;

    assign rep_wrap = (rep_cnt + 8'd1) == 8'(REPEAT_INTERVAL);
    // A swap already offers the packet, so it restarts the interval instead.
    assign rep_fire = !swap && bus.frame_start && active_valid && rep_wrap;

    always_ff @(posedge clk_pixel) begin
        if (!reset_n)                           rep_cnt <= '0;
        else if (swap)                          rep_cnt <= '0;
        else if (bus.frame_start && active_valid) rep_cnt <= rep_wrap ? 8'd0 : rep_cnt + 8'd1;
    end
`else
    // Interval only matters in repeat builds.
    logic unused_repeat;
    assign unused_repeat = ^8'(REPEAT_INTERVAL);
    assign rep_fire      = 1'b0;
`endif

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            bus.header   <= '0;
            bus.sub      <= '0;
            bus.tx_valid <= 1'b0;
            bus.missed   <= 1'b0;
            active_valid <= 1'b0;
        end else begin
            // Active buffer only moves on a swap: stable for the whole frame.
            if (swap) begin
                bus.header   <= build_header(TYPE, VERSION, length);
                bus.sub      <= shadow_sub;
                active_valid <= 1'b1;
            end
            if (bus.frame_start && bus.tx_valid) bus.missed <= 1'b1;
            if (swap || rep_fire) bus.tx_valid <= 1'b1;
            else if (handshake)   bus.tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dynamic_info_frame.sv
// tb_dynamic_info_frame -- two sources (MAX_LENGTH 27 and 4) share one stimulus
// stream; a byte-list model predicts every output each cycle, and directed
// scenarios pin known packets.
module tb_dynamic_info_frame;

    logic       clk_pixel = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_valid = 1'b0, wr_last = 1'b0, frame_start = 1'b0, tx_ready = 1'b0;
    logic [7:0] wr_data = 8'h00;

    int checks = 0;
    int fails  = 0;
    bit comp_en = 1'b0;

    always #5 clk_pixel = ~clk_pixel;

    dynamic_info_frame_if if0();
    dynamic_info_frame_if if1();

    assign if0.wr_valid = wr_valid;   assign if1.wr_valid = wr_valid;
    assign if0.wr_data  = wr_data;    assign if1.wr_data  = wr_data;
    assign if0.wr_last  = wr_last;    assign if1.wr_last  = wr_last;
    assign if0.frame_start = frame_start; assign if1.frame_start = frame_start;
    assign if0.tx_ready = tx_ready;   assign if1.tx_ready = tx_ready;

    dynamic_info_frame #(.TYPE(7'h02), .VERSION(8'h02), .MAX_LENGTH(27), .REPEAT_INTERVAL(2))
        u0 (.clk_pixel(clk_pixel), .reset_n(reset_n), .bus(if0.slave));
    dynamic_info_frame #(.TYPE(7'h02), .VERSION(8'h02), .MAX_LENGTH(4), .REPEAT_INTERVAL(2))
        u1 (.clk_pixel(clk_pixel), .reset_n(reset_n), .bus(if1.slave));

    logic         o_wrr[2], o_txv[2], o_ovf[2], o_mis[2];
    logic [23:0]  o_hdr[2];
    logic [223:0] o_sub[2];
    assign o_wrr[0] = if0.wr_ready; assign o_wrr[1] = if1.wr_ready;
    assign o_txv[0] = if0.tx_valid; assign o_txv[1] = if1.tx_valid;
    assign o_ovf[0] = if0.overflow; assign o_ovf[1] = if1.overflow;
    assign o_mis[0] = if0.missed;   assign o_mis[1] = if1.missed;
    assign o_hdr[0] = if0.header;   assign o_hdr[1] = if1.header;
    assign o_sub[0] = if0.sub;      assign o_sub[1] = if1.sub;

    task automatic chk(input string nm, input logic [223:0] act, input logic [223:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           maxl[2] = '{27, 4};
    logic [7:0]   m_q[2][$];
    bit           m_ld[2], m_ldovf[2], m_pend[2], m_av[2], m_tx[2], m_mis[2], m_ovf[2];
    int           m_rc[2];
    logic [23:0]  m_hdr[2], m_phdr[2];
    logic [223:0] m_sub[2], m_psub[2];

    // Packet from a byte list: length, payload bytes, and PB0 that zeroes the sum.
    function automatic void build(input logic [7:0] q[$], output logic [23:0] h,
                                  output logic [223:0] s);
        int tot;
        tot = 'h82 + 'h02 + q.size();
        s = '0;
        foreach (q[j]) begin
            tot += q[j];
            s[8*(j+1) +: 8] = q[j];
        end
        s[7:0] = 8'((256 - (tot % 256)) % 256);
        h = {8'(q.size()), 8'h02, 8'h82};
    endfunction

    always @(posedge clk_pixel) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                m_q[d].delete();
                m_ld[d] = 0; m_ldovf[d] = 0; m_pend[d] = 0; m_av[d] = 0;
                m_tx[d] = 0; m_mis[d] = 0; m_ovf[d] = 0; m_rc[d] = 0;
                m_hdr[d] = '0; m_sub[d] = '0;
            end else begin
                bit acc, swp;
                acc = wr_valid && !m_pend[d];
                swp = frame_start && m_pend[d];
                if (frame_start && m_tx[d]) m_mis[d] = 1;
                if (m_tx[d] && tx_ready) m_tx[d] = 0;
`ifdef INFO_FRAME_REPEAT_EN
                if (swp) m_rc[d] = 0;
                else if (frame_start && m_av[d]) begin
                    m_rc[d]++;
                    if (m_rc[d] == 2) begin m_rc[d] = 0; m_tx[d] = 1; end
                end
`endif
                if (swp) begin
                    m_hdr[d] = m_phdr[d]; m_sub[d] = m_psub[d];
                    m_av[d] = 1; m_tx[d] = 1; m_pend[d] = 0;
                end
                if (acc) begin
                    if (!m_ld[d]) begin m_q[d].delete(); m_ldovf[d] = 0; m_ld[d] = 1; end
                    if (m_q[d].size() < maxl[d]) m_q[d].push_back(wr_data);
                    else begin m_ovf[d] = 1; m_ldovf[d] = 1; end
                    if (wr_last) begin
                        m_ld[d] = 0;
                        if (!m_ldovf[d]) begin
                            build(m_q[d], m_phdr[d], m_psub[d]);
                            m_pend[d] = 1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk_pixel) begin
        if (comp_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("wr_ready[%0d]", d), 224'(o_wrr[d]), 224'(!m_pend[d]));
                chk($sformatf("tx_valid[%0d]", d), 224'(o_txv[d]), 224'(m_tx[d]));
                chk($sformatf("overflow[%0d]", d), 224'(o_ovf[d]), 224'(m_ovf[d]));
                chk($sformatf("missed[%0d]", d),   224'(o_mis[d]), 224'(m_mis[d]));
                chk($sformatf("header[%0d]", d),   224'(o_hdr[d]), 224'(m_hdr[d]));
                chk($sformatf("sub[%0d]", d),      o_sub[d],       m_sub[d]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic load(input logic [7:0] b[$]);
        foreach (b[i]) begin
            wr_valid = 1; wr_data = b[i]; wr_last = (i == b.size() - 1);
            @(negedge clk_pixel);
        end
        wr_valid = 0; wr_last = 0;
    endtask

    task automatic pulse_fs();
        frame_start = 1; @(negedge clk_pixel); frame_start = 0;
    endtask

    task automatic take();
        tx_ready = 1; @(negedge clk_pixel); tx_ready = 0;
    endtask

    initial begin
        logic [7:0] q[$];
        repeat (3) @(negedge clk_pixel);
        reset_n = 1;
        comp_en = 1;
        chk("rst_wr_ready", 224'(if0.wr_ready), 224'(1));
        chk("rst_tx_valid", 224'(if0.tx_valid), 224'(0));
        chk("rst_header",   224'(if0.header),   224'(0));

        // 3-byte load
        q = {8'h01, 8'h02, 8'h03};
        load(q);
        chk("s1_wr_ready_pending", 224'(if0.wr_ready), 224'(0));
        pulse_fs();
        chk("s1_tx_valid", 224'(if0.tx_valid), 224'(1));
        chk("s1_header",   224'(if0.header),   224'(24'h030282));
        chk("s1_sub",      if0.sub,            224'(56'h00000003020173));
        chk("s1_header_u1", 224'(if1.header),  224'(24'h030282));
        take();
        chk("s1_tx_drop", 224'(if0.tx_valid), 224'(0));

        // 13 zero bytes: fits u0, overflows u1
        q = {};
        repeat (13) q.push_back(8'h00);
        load(q);
        pulse_fs();
        chk("s2_header",   224'(if0.header),   224'(24'h0D0282));
        chk("s2_sub",      if0.sub,            224'(56'h6F));
        chk("s2_u1_ovf",   224'(if1.overflow), 224'(1));
        chk("s2_u1_hdr",   224'(if1.header),   224'(24'h030282));
        chk("s2_u1_txv",   224'(if1.tx_valid), 224'(0));
        take();
        chk("s2_tx_drop",  224'(if0.tx_valid), 224'(0));

        // reset in the middle of a load
        wr_valid = 1; wr_data = 8'h55; wr_last = 0;
        repeat (2) @(negedge clk_pixel);
        wr_valid = 0; reset_n = 0;
        @(negedge clk_pixel);
        reset_n = 1;
        chk("s3_wr_ready", 224'(if0.wr_ready), 224'(1));
        chk("s3_header",   224'(if0.header),   224'(0));
        chk("s3_u1_ovf",   224'(if1.overflow), 224'(0));
        q = {8'h01, 8'h02, 8'h03};
        load(q);
        pulse_fs();
        chk("s3_header_after", 224'(if0.header), 224'(24'h030282));
        chk("s3_sub_after",    if0.sub,          224'(56'h00000003020173));

        // second frame_start with the offer still open
        chk("s4_missed_before", 224'(if0.missed), 224'(0));
        pulse_fs();
        chk("s4_missed",   224'(if0.missed),   224'(1));
        chk("s4_tx_valid", 224'(if0.tx_valid), 224'(1));
        take();

        // 6 bytes into MAX_LENGTH=4
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1; wr_data = 8'(8'h10 + i); wr_last = (i == 5);
            @(negedge clk_pixel);
            chk($sformatf("s5_ovf_b%0d", i + 1), 224'(if1.overflow), 224'(i >= 4));
        end
        wr_valid = 0; wr_last = 0;
        pulse_fs();
        chk("s5_u1_hdr", 224'(if1.header), 224'(24'h030282));
        chk("s5_u1_sub", if1.sub,          224'(56'h00000003020173));
        take();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            wr_valid    = ($urandom % 4) != 0;
            wr_data     = 8'($urandom);
            wr_last     = ($urandom % 12) == 0;
            frame_start = ($urandom % 16) == 0;
            tx_ready    = ($urandom % 3) == 0;
            reset_n     = ($urandom % 700) != 0;
            @(negedge clk_pixel);
        end
        wr_valid = 0; wr_last = 0; frame_start = 0; tx_ready = 0; reset_n = 1;
        @(negedge clk_pixel);
        comp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/dynamic_info_frame.md
# dynamic_info_frame

Runtime-loadable, double-buffered HDMI InfoFrame source. Data bytes arrive over a byte-stream write port into a shadow buffer. The block computes the PB0 checksum, swaps the shadow buffer into the active buffer on a frame boundary, and offers the finished header and four subpackets to the data-island packet picker through a valid/ready handshake. It is the runtime-programmable successor to the fixed-content, parameter-built InfoFrame generators, and sits beside them as a packet source.

## Interface
Parameters:
- TYPE, 7'h02 — InfoFrame type; header byte 0 is {1'b1, TYPE}.
- VERSION, 8'h02 — header byte 1.
- MAX_LENGTH, 27 — maximum data bytes PB1..PBn; legal range 1..27.
- REPEAT_INTERVAL, 1 — frames between retransmissions; 1..255; used only with INFO_FRAME_REPEAT_EN.

Ports (clock and reset first):
- clk_pixel  in  1  pixel clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- wr_valid  in  1  write byte valid.
- wr_ready  out  1  block accepts a byte.
- wr_data  in  8  next data byte, PB1 first.
- wr_last  in  1  marks the final byte of a load; commits the load.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- tx_valid  out  1  packet available.
- tx_ready  in  1  picker has latched the packet.
- header  out  24  {length, VERSION, {1'b1, TYPE}}.
- sub  out  4x56  subpackets 0..3; byte k of sub[i] is PB(7i+k), with PB0 in the LSB.
- overflow  out  1  sticky; a load exceeded MAX_LENGTH.
- missed  out  1  sticky; frame_start arrived while tx_valid was still high.

## Operation
Loader states:
- IDLE: wr_ready=1. An accepted byte goes to LOAD.
- LOAD: each byte is stored at index count+1; the running sum adds the byte; count increments.
- Accepting a byte with wr_last moves LOAD to PENDING. If the load overflowed, it returns to IDLE and the load is discarded.
- A wr_last byte accepted in IDLE is a 1-byte load.
- PENDING: wr_ready=0 until the swap.

Overflow:
- A byte beyond MAX_LENGTH is dropped and sets overflow.
- The remainder of that load is consumed until wr_last.

Checksum and sum width:
- Checksum = -((0x80|TYPE) + VERSION + length + Σ bytes) mod 256.
- The sum is an 8-bit wrapping adder.
- The checksum is registered on the transition into PENDING.

Shadow buffer:
- Unwritten shadow bytes read as zero.
- The shadow buffer is cleared on entry to LOAD.

Swap:
- Happens on the frame_start cycle when the loader is in PENDING.
- Shadow copies to active, active_valid is set, and the loader goes to IDLE.
- header and sub change only on this cycle, so they are stable for a full frame.

Transmit:
- The cycle after a swap, tx_valid=1.
- tx_valid stays high until a cycle with tx_valid&tx_ready, then drops.
- If frame_start arrives while tx_valid=1, missed is set and tx_valid stays high. A swap is still allowed in that case.

Reset (reset_n=0):
- All outputs go to 0, except wr_ready=1.
- The loader goes to IDLE, active_valid=0, and the repeat counter=0.
- Reset mid-load discards the partial load.

## Timing
- Byte accepted on a wr_valid&wr_ready cycle; throughput is 1 byte/cycle.
- wr_last accepted at cycle N: the loader is PENDING from N+1.
- A frame_start at N+1 or later performs the swap.
- frame_start at cycle F with PENDING: header/sub update at F+1, and tx_valid=1 at F+1.
- Handshake at cycle H: tx_valid=0 at H+1.
- frame_start and wr_last on the same cycle: the load is not yet PENDING, so the swap waits for the next frame_start.

## Configuration
INFO_FRAME_REPEAT_EN:
- Defined: a frame counter counts frame_start pulses while active_valid=1. When it reaches REPEAT_INTERVAL, it resets and raises tx_valid at F+1 even without a new load. A swap resets the counter.
- Undefined: tx_valid is raised only after a swap (send-on-change). REPEAT_INTERVAL is ignored.

## Structure
- Package info_frame_pkg: type codes (AVI 7'h02, SPD 7'h03, AUDIO 7'h04) and a header-build function.
- Also in info_frame_pkg: the checksum function and a 4x56 subpacket typedef.
- Sub-module info_frame_shadow_loader: IDLE/LOAD/PENDING FSM, shadow bytes, running sum, overflow.
- The top level holds the active buffer, the handshake, and the repeat logic.

## Test plan
- TYPE=7'h02, VERSION=2; write bytes 01,02,03 (last on 03); pulse frame_start → header=24'h030282, sub[0]=56'h00000003020173, sub[1..3]=0, tx_valid=1 the next cycle.
- Write 13 bytes of 0x00; frame_start; tx_ready → header=24'h0D0282, sub[0]=56'h6F; tx_valid drops the cycle after the handshake.
- MAX_LENGTH=4; write 6 bytes → overflow=1 from the 5th byte; the load is discarded; a following frame_start leaves header/sub and tx_valid unchanged.
- Commit a load, then issue two frame_starts without tx_ready → missed=1 after the second; tx_valid stays 1.
- Assert reset_n=0 mid-load after 2 bytes → wr_ready=1, all outputs 0; a new 3-byte load then produces the first scenario's values.
- With INFO_FRAME_REPEAT_EN and REPEAT_INTERVAL=2: one load, then handshake on each offer → tx_valid re-raised after every second frame_start, with identical header/sub.
